alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller that sequences the 8-bit ALU through a short, software-loaded program of register-to-register operations.
- Owns a small register file and an instruction buffer.
- For each instruction: drives the ALU operands and 4-bit op select, waits the ALU latency, then writes the result back.
- Sits between the host/config side (program and register load, start) and the ALU instance (alu_a, alu_b, alu_sel out; alu_result in).

Parameters:
- DATA_W, 8, ALU operand/result width and register width.
- PROG_DEPTH, 16, instruction buffer entries; PA_W = clog2(PROG_DEPTH).
- ALU_LAT, 1, clock edges from ALU operand/select change to a valid alu_result (1 or more).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  instruction buffer write enable.
- prog_addr  in  PA_W  instruction buffer write address.
- prog_data  in  10  instruction: [9:6] op, [5:4] ra, [3:2] rb, [1:0] rd.
- prog_len  in  PA_W+1  number of instructions to run; sampled on start.
- reg_we  in  1  host write to register file.
- reg_waddr  in  2  host register write address.
- reg_wdata  in  DATA_W  host register write data.
- reg_raddr  in  2  host read address.
- reg_rdata  out  DATA_W  combinational read of rf[reg_raddr].
- start  in  1  begin execution at instruction 0.
- busy  out  1  high while a program runs.
- done  out  1  one-cycle pulse when the program completes.
- alu_a  out  DATA_W  ALU operand A, registered.
- alu_b  out  DATA_W  ALU operand B, registered.
- alu_sel  out  4  ALU op select, registered.
- alu_result  in  DATA_W  ALU output.

Behaviour:
- Reset (takes effect at the next clk edge with rst high):
  - state=IDLE; pc=0; busy=0; done=0; alu_a=alu_b=0; alu_sel=4'b0000.
  - Register file rf[0..3]=0. Instruction buffer contents are not reset.
- Reset mid-program aborts immediately, with no writeback and no done pulse.
- FSM states: IDLE, ISSUE, WAIT, WB, DONE.
- IDLE:
  - prog_we writes buf[prog_addr]; reg_we writes rf[reg_waddr].
  - start=1 latches len=prog_len and sets pc=0.
  - If len==0, go to DONE; otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Register alu_a=rf[ra], alu_b=rf[rb], alu_sel=op from buf[pc].
  - Load the wait counter with ALU_LAT, then go to WAIT.
- WAIT (ALU_LAT cycles):
  - alu_a, alu_b and alu_sel are held stable.
  - Decrement the counter; go to WB when it reaches 1.
- WB (1 cycle):
  - rf[rd] <= alu_result at the closing edge.
  - pc++; if pc+1==len, go to DONE, else go to ISSUE.
- DONE (1 cycle): done=1, then go to IDLE.
- Timing:
  - Each instruction takes ALU_LAT+2 cycles.
  - With start sampled at edge k: busy=1 from cycle k+1 through the end of the last WB; done is high in cycle k+1+N*(ALU_LAT+2).
  - len==0: done in cycle k+1; busy stays 0.
- alu_sel is passed through unchanged; the sequencer does not decode ops. Stateful ALU ops (MAC accumulator) are the ALU's concern.
- Hazards: instructions are strictly serial, so a result written in WB is visible to the next ISSUE (read-after-write correct, no forwarding needed).
- While busy or in DONE:
  - start, prog_we and reg_we are ignored.
  - reg_rdata stays live for observation.
- rd==ra/rb is allowed; the old value is used as the operand.
- prog_len > PROG_DEPTH saturates to PROG_DEPTH.
- pc never wraps past PROG_DEPTH-1.

Optional Feature:
- Macro ALU_OP_SEQUENCER_CYCCNT_EN.
- Defined:
  - Adds output cyc_cnt (16 bits).
  - Cleared on start accepted and on rst.
  - Increments every cycle busy=1; saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset all outputs: after rst, alu_sel=0, alu_a=alu_b=0, busy=0, done=0; all 4 reg_rdata reads return 0.
- Single ADD:
  - Stimulus: rf0=8'h4D, rf1=8'h17; buf0={4'b0000,ra=0,rb=1,rd=2}; len=1; ALU_LAT=1; start.
  - Response: done exactly 4 cycles after the start edge; rf2=8'h64; alu_sel=0000 held through WAIT.
- Chained RAW:
  - Stimulus: ADD r2=r0+r1, then ROR (0111) r3=r2 by r1; len=2.
  - Response: second ISSUE drives alu_a=8'h64; rf3 equals the ALU's ROR result; done at cycle 1+2*3.
- LTH compare:
  - Stimulus: op 1111 with rf1=8'h17, rf0=8'h4D.
  - Response: rd gets the ALU's less-than result (8'h01); busy drops the cycle done rises.
- Boundaries:
  - len=0: done one cycle after start, busy stays 0.
  - start and reg_we pulsed while busy: no effect on pc or rf.
  - rst asserted in WAIT: IDLE next cycle, no writeback, no done.
- With ALU_OP_SEQUENCER_CYCCNT_EN: two-instruction program with ALU_LAT=1 leaves cyc_cnt=6.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Runs a short, host-loaded program of register-to-register operations through
// an external ALU. Owns a 4-entry register file and a PROG_DEPTH-entry
// instruction buffer.
//
// Each instruction takes ALU_LAT+2 cycles:
//   ISSUE (operands and op select are registered out to the ALU),
//   WAIT  (ALU_LAT cycles, operands held stable),
//   WB    (alu_result written to rf[rd]).
//
// Instruction format: [9:6] op, [5:4] ra, [3:2] rb, [1:0] rd.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   prog_we/addr/data    instruction buffer write (accepted only when idle)
//   prog_len             number of instructions to run, sampled on start
//   reg_we/waddr/wdata   host register write (accepted only when idle)
//   reg_raddr/rdata      combinational register read, always live
//   start                begin execution at instruction 0 (accepted when idle)
//   busy                 high while instructions are executing
//   done                 one-cycle pulse when the program completes
//   alu_a/alu_b/alu_sel  registered ALU operands and op select
//   alu_result           ALU output, captured in WB
//   cyc_cnt              busy-cycle counter, present only when the macro
//                        ALU_OP_SEQUENCER_CYCCNT_EN is defined
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DATA_W     = 8,
    parameter int PROG_DEPTH = 16,
    parameter int ALU_LAT    = 1,
    localparam int PA_W      = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PA_W-1:0]   prog_addr,
    input  logic [9:0]        prog_data,
    input  logic [PA_W:0]     prog_len,
    input  logic              reg_we,
    input  logic [1:0]        reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic [1:0]        reg_raddr,
    output logic [DATA_W-1:0] reg_rdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result
`ifdef ALU_OP_SEQUENCER_CYCCNT_EN
    ,
    output logic [15:0]       cyc_cnt
`endif
);

    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [PA_W:0] DEPTH_L = (PA_W + 1)'(PROG_DEPTH);
    localparam logic [PA_W:0] ONE_L   = (PA_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_n;

    logic [9:0]        prog_buf [PROG_DEPTH];
    logic [DATA_W-1:0] rf [4];
    logic [PA_W-1:0]   pc;
    logic [PA_W:0]     len_q;
    logic [CW-1:0]     wcnt;

    logic [9:0]        instr;
    logic [PA_W:0]     pc_inc;
    logic              last;

    // Program length larger than the buffer runs the whole buffer once.
    function automatic logic [PA_W:0] sat_len(input logic [PA_W:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    assign instr     = prog_buf[pc];
    assign pc_inc    = {1'b0, pc} + ONE_L;
    assign last      = (pc_inc == len_q);
    assign reg_rdata = rf[reg_raddr];
    assign busy      = (state == ISSUE) || (state == WAIT) || (state == WB);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (prog_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE:   state_n = WAIT;
            WAIT: begin
                if (wcnt == CW'(1)) begin
                    state_n = WB;
                end
            end
            WB:      state_n = last ? DONE : ISSUE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Instruction buffer: host-loaded while idle, never reset.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && prog_we) begin
            prog_buf[prog_addr] <= prog_data;
        end
    end

    // Sequencer datapath: register file, pc, ALU operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            len_q   <= '0;
            wcnt    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (reg_we) begin
                        rf[reg_waddr] <= reg_wdata;
                    end
                    if (start) begin
                        len_q <= sat_len(prog_len);
                        pc    <= '0;
                    end
                end
                ISSUE: begin
                    alu_a   <= rf[instr[5:4]];
                    alu_b   <= rf[instr[3:2]];
                    alu_sel <= instr[9:6];
                    wcnt    <= CW'(ALU_LAT);
                end
                WAIT: begin
                    wcnt <= wcnt - CW'(1);
                end
                WB: begin
                    rf[instr[1:0]] <= alu_result;
                    // pc stays on the final instruction so it never wraps.
                    if (!last) begin
                        pc <= pc_inc[PA_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_CYCCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts cycles spent busy; holds after done until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            cyc_cnt <= 16'd0;
        end else if (busy) begin
            cyc_cnt <= sat_inc16(cyc_cnt);
        end
    end
`else
    // Busy-cycle counter not built.
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int DATA_W     = 8;
    localparam int PROG_DEPTH = 16;
    localparam int ALU_LAT    = 1;
    localparam int PA_W       = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [PA_W-1:0]   prog_addr;
    logic [9:0]        prog_data;
    logic [PA_W:0]     prog_len;
    logic              reg_we;
    logic [1:0]        reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic [1:0]        reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
`ifdef ALU_OP_SEQUENCER_CYCCNT_EN
    logic [15:0]       cyc_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(
        .DATA_W    (DATA_W),
        .PROG_DEPTH(PROG_DEPTH),
        .ALU_LAT   (ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_result(alu_result)
`ifdef ALU_OP_SEQUENCER_CYCCNT_EN
        ,
        .cyc_cnt   (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External ALU stand-in with one cycle of latency.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
        logic [15:0] dbl;
        dbl = {a, a} >> b[2:0];
        case (s)
            4'b0000: return a + b;
            4'b0111: return dbl[7:0];
            4'b1111: return {7'd0, (a < b)};
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_sel);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic write_prog(input logic [3:0] a, input logic [9:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        reg_raddr = a;
        #1;
        d = reg_rdata;
    endtask

    // Returns the cycle index (start edge = cycle 0 boundary) at which done is seen.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (alu_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_sel got %h want 0", alu_sel); end
        n_checks++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a got %h want 00", alu_a); end
        n_checks++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b got %h want 00", alu_b); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_rf%0d got %h want 00", i, v); end
        end
    endtask

    task automatic test_single_add();
        logic [7:0] v;
        write_reg(2'd0, 8'h4D);
        write_reg(2'd1, 8'h17);
        write_prog(4'd0, {4'b0000, 2'd0, 2'd1, 2'd2});
        prog_len = 5'd1;
        start = 1'b1;
        tick();                                   // cycle 1: ISSUE
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_c1 got %b want 1", busy); end
        tick();                                   // cycle 2: WAIT
        n_checks++; if (alu_a !== 8'h4D || alu_b !== 8'h17) begin n_fail++; $display("FAIL add_operands got %h/%h want 4d/17", alu_a, alu_b); end
        n_checks++; if (alu_sel !== 4'b0000) begin n_fail++; $display("FAIL add_sel_wait got %h want 0", alu_sel); end
        tick();                                   // cycle 3: WB
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL add_wb_state got done=%b busy=%b want 0/1", done, busy); end
        tick();                                   // cycle 4: DONE
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done_c4 got %b want 1", done); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got %b want 0", done); end
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h64) begin n_fail++; $display("FAIL add_rf2 got %h want 64", v); end
    endtask

    task automatic test_chained_raw();
        logic [7:0] v;
        int cyc;
        write_reg(2'd2, 8'h00);
        write_prog(4'd0, {4'b0000, 2'd0, 2'd1, 2'd2});
        write_prog(4'd1, {4'b0111, 2'd2, 2'd1, 2'd3});
        prog_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();        // cycle 5: WAIT of instruction 1
        n_checks++; if (alu_a !== 8'h64) begin n_fail++; $display("FAIL raw_alu_a got %h want 64", alu_a); end
        n_checks++; if (alu_sel !== 4'b0111) begin n_fail++; $display("FAIL raw_alu_sel got %h want 7", alu_sel); end
        wait_done(60, cyc);
        cyc = cyc + 4;
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL raw_done_cycle got %0d want 7", cyc); end
        tick();
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'hC8) begin n_fail++; $display("FAIL raw_rf3 got %h want c8", v); end
`ifdef ALU_OP_SEQUENCER_CYCCNT_EN
        n_checks++; if (cyc_cnt !== 16'd6) begin n_fail++; $display("FAIL cyccnt got %0d want 6", cyc_cnt); end
        tick();
        n_checks++; if (cyc_cnt !== 16'd6) begin n_fail++; $display("FAIL cyccnt_hold got %0d want 6", cyc_cnt); end
`endif
    endtask

    task automatic test_lth();
        logic [7:0] v;
        write_prog(4'd0, {4'b1111, 2'd1, 2'd0, 2'd3});
        prog_len = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                            // cycle 3: WB
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL lth_c3 got busy=%b done=%b want 1/0", busy, done); end
        tick();                                    // cycle 4: DONE
        n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL lth_c4 got busy=%b done=%b want 0/1", busy, done); end
        tick();
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL lth_rf3 got %h want 01", v); end
    endtask

    task automatic test_len_zero();
        prog_len = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_c1 got done=%b busy=%b want 1/0", done, busy); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_c2 got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_ignore_while_busy();
        logic [7:0] v;
        write_reg(2'd2, 8'h00);
        write_prog(4'd0, {4'b0000, 2'd0, 2'd1, 2'd2});
        prog_len = 5'd1;
        start = 1'b1;
        tick();                                    // cycle 1: ISSUE
        reg_we = 1'b1; reg_waddr = 2'd0; reg_wdata = 8'hFF;
        tick();                                    // cycle 2
        n_checks++; if (alu_a !== 8'h4D) begin n_fail++; $display("FAIL busy_alu_a got %h want 4d", alu_a); end
        tick(); tick();                            // cycle 4: DONE
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_done got %b want 1", done); end
        tick();                                    // cycle 5: back in IDLE
        start = 1'b0; reg_we = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_restart got busy=%b done=%b want 0/0", busy, done); end
        read_reg(2'd0, v);
        n_checks++; if (v !== 8'h4D) begin n_fail++; $display("FAIL busy_rf0 got %h want 4d", v); end
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h64) begin n_fail++; $display("FAIL busy_rf2 got %h want 64", v); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic [7:0] v;
        int seen_done;
        write_reg(2'd3, 8'h5A);
        write_prog(4'd0, {4'b0000, 2'd0, 2'd1, 2'd3});
        prog_len = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                                    // cycle 2: WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || alu_a !== 8'h00) begin n_fail++; $display("FAIL rstwait_idle got busy=%b alu_a=%h want 0/00", busy, alu_a); end
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            tick();
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL rstwait_no_done got %0d active cycles want 0", seen_done); end
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rstwait_rf3 got %h want 00", v); end
    endtask

    task automatic test_len_saturate();
        logic [7:0] v;
        int cyc;
        write_reg(2'd1, 8'h01);
        write_reg(2'd2, 8'h00);
        for (int i = 0; i < PROG_DEPTH; i++) begin
            write_prog(4'(i), {4'b0000, 2'd2, 2'd1, 2'd2});
        end
        prog_len = 5'd31;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, cyc);
        n_checks++; if (cyc !== 49) begin n_fail++; $display("FAIL sat_done_cycle got %0d want 49", cyc); end
        tick();
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h10) begin n_fail++; $display("FAIL sat_rf2 got %h want 10", v); end
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0; reg_raddr = '0; start = 1'b0;
        test_reset();
        test_single_add();
        test_chained_raw();
        test_lth();
        test_len_zero();
        test_ignore_while_busy();
        test_reset_in_wait();
        test_len_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
